// File: rtl/servo_pkg.sv
// Shared constants, width type and FSM state encoding for the servo frame scheduler.
// SERVO_SLEW_EN selects per-frame slew limiting of channel widths.
package servo_pkg;

  localparam int DEF_FRAME_TICKS  = 2000000;
  localparam int DEF_MIN_TICKS    = 50000;
  localparam int DEF_MAX_TICKS    = 250000;
  localparam int DEF_CENTER_TICKS = 150000;
  localparam int DEF_GAP_TICKS    = 25000;
  localparam int DEF_SLEW_TICKS   = 12500;

  localparam int WIDTH_W = 18;
  typedef logic [WIDTH_W-1:0] width_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    HOLD  = 2'd3
  } servo_state_t;

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

endpackage

// File: rtl/servo_width_limiter.sv
// Combinational width conditioning: clamp to the safe servo range, and in step mode
// move from the current width toward the clamped request (slew-limited when SERVO_SLEW_EN).
module servo_width_limiter
  import servo_pkg::*;
#(
  parameter int MIN_TICKS  = DEF_MIN_TICKS,
  parameter int MAX_TICKS  = DEF_MAX_TICKS,
  parameter int SLEW_TICKS = DEF_SLEW_TICKS,
  parameter bit STEP       = 1'b0
) (
  input  width_t req,
  input  width_t cur,
  output width_t y
);

  // Without slew limiting the bound is never reached: |req - cur| < MAX_TICKS.
  localparam int LIMIT = SLEW_EN ? SLEW_TICKS : MAX_TICKS;
  localparam logic signed [WIDTH_W:0] LIM_POS = (WIDTH_W+1)'(LIMIT);
  localparam logic signed [WIDTH_W:0] LIM_NEG = -((WIDTH_W+1)'(LIMIT));

  width_t clamped;
  logic signed [WIDTH_W:0] delta;
  logic signed [WIDTH_W:0] step;
  logic signed [WIDTH_W:0] sum;

  always_comb begin
    if (req < width_t'(MIN_TICKS)) begin
      clamped = width_t'(MIN_TICKS);
    end else if (req > width_t'(MAX_TICKS)) begin
      clamped = width_t'(MAX_TICKS);
    end else begin
      clamped = req;
    end

    delta = $signed({1'b0, clamped}) - $signed({1'b0, cur});
    if (delta > LIM_POS) begin
      step = LIM_POS;
    end else if (delta < LIM_NEG) begin
      step = LIM_NEG;
    end else begin
      step = delta;
    end

    sum = $signed({1'b0, cur}) + step;
    y   = STEP ? sum[WIDTH_W-1:0] : clamped;
  end

endmodule

// File: rtl/servo_frame_scheduler.sv
// Multi-channel servo pulse scheduler: fixed frame timebase, back-to-back channel pulses.
// Build option SERVO_SLEW_EN: slew-limit each channel's width change per frame.
module servo_frame_scheduler
  import servo_pkg::*;
#(
  parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
  parameter int N_CH         = 4,
  parameter int MIN_TICKS    = DEF_MIN_TICKS,
  parameter int MAX_TICKS    = DEF_MAX_TICKS,
  parameter int CENTER_TICKS = DEF_CENTER_TICKS,
  parameter int GAP_TICKS    = DEF_GAP_TICKS,
  parameter int SLEW_TICKS   = DEF_SLEW_TICKS,
  localparam int CH_W        = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CH_W-1:0]  cmd_ch,
  input  logic [17:0]      cmd_width,
  output logic [N_CH-1:0]  servo_out,
  output logic             frame_start,
  output logic [CH_W-1:0]  active_ch,
  output logic             pulse_active,
  output servo_state_t     dbg_state
);

  localparam int FW = $clog2(FRAME_TICKS);

  generate
    if ((N_CH < 2) || (N_CH > 8) ||
        (N_CH * (MAX_TICKS + GAP_TICKS) > FRAME_TICKS) ||
        (MIN_TICKS > CENTER_TICKS) || (CENTER_TICKS > MAX_TICKS)) begin : g_bad_params
      $error("servo_frame_scheduler: illegal parameter combination");
    end
  endgenerate

  // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready is low in reset and high otherwise, so the source never stalls.
  logic [FW-1:0]   fcnt;
  logic            wrap;
  width_t          shadow   [N_CH];
  width_t          width    [N_CH];
  width_t          width_nx [N_CH];
  width_t          cmd_clamped;
  width_t          pcnt, pcnt_d;
  logic [CH_W-1:0] ch, ch_d, ch_inc;
  servo_state_t    state, state_d;
  logic [N_CH-1:0] servo_d;

  assign wrap      = (fcnt == FW'(FRAME_TICKS - 1));
  assign ch_inc    = ch + 1'b1;
  assign dbg_state = state;

  servo_width_limiter #(
    .MIN_TICKS (MIN_TICKS),
    .MAX_TICKS (MAX_TICKS),
    .SLEW_TICKS(SLEW_TICKS),
    .STEP      (1'b0)
  ) u_cmd_clamp (
    .req(cmd_width),
    .cur('0),
    .y  (cmd_clamped)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_latch
    servo_width_limiter #(
      .MIN_TICKS (MIN_TICKS),
      .MAX_TICKS (MAX_TICKS),
      .SLEW_TICKS(SLEW_TICKS),
      .STEP      (1'b1)
    ) u_step (
      .req(shadow[i]),
      .cur(width[i]),
      .y  (width_nx[i])
    );
  end

  // Wrap overrides every state; channel 0 uses the width being latched on this edge.
  always_comb begin
    state_d = state;
    ch_d    = ch;
    pcnt_d  = pcnt;
    servo_d = '0;
    if (wrap) begin
      state_d    = PULSE;
      ch_d       = '0;
      pcnt_d     = width_nx[0] - 1'b1;
      servo_d[0] = 1'b1;
    end else begin
      case (state)
        PULSE: begin
          if (pcnt == '0) begin
            state_d = (int'(ch) == N_CH - 1) ? HOLD : GAP;
            pcnt_d  = width_t'(GAP_TICKS - 1);
          end else begin
            pcnt_d      = pcnt - 1'b1;
            servo_d[ch] = 1'b1;
          end
        end
        GAP: begin
          if (pcnt == '0) begin
            state_d         = PULSE;
            ch_d            = ch_inc;
            pcnt_d          = width[ch_inc] - 1'b1;
            servo_d[ch_inc] = 1'b1;
          end else begin
            pcnt_d = pcnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt         <= FW'(FRAME_TICKS - 1);
      state        <= IDLE;
      ch           <= '0;
      pcnt         <= '0;
      servo_out    <= '0;
      frame_start  <= 1'b0;
      active_ch    <= '0;
      pulse_active <= 1'b0;
      cmd_ready    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= width_t'(CENTER_TICKS);
        width[i]  <= width_t'(CENTER_TICKS);
      end
    end else begin
      fcnt         <= wrap ? '0 : fcnt + 1'b1;
      state        <= state_d;
      ch           <= ch_d;
      pcnt         <= pcnt_d;
      servo_out    <= servo_d;
      frame_start  <= wrap;
      active_ch    <= ch_d;
      pulse_active <= |servo_d;
      cmd_ready    <= 1'b1;
      if (wrap) begin
        for (int i = 0; i < N_CH; i++) begin
          width[i] <= width_nx[i];
        end
      end
      // Out-of-range channels are accepted and dropped.
      if (cmd_valid && cmd_ready && (int'(cmd_ch) < N_CH)) begin
        shadow[cmd_ch] <= cmd_clamped;
      end
    end
  end

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed bench for servo_frame_scheduler with scaled-down frame timing.
// Expected pulse trains are rebuilt each frame from hand-computed channel widths.
module tb_servo_frame_scheduler;

  localparam int FT   = 200;
  localparam int NCH  = 4;
  localparam int MINW = 5;
  localparam int MAXW = 25;
  localparam int CENW = 15;
  localparam int GAPW = 3;
  localparam int SLEW = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [1:0]            cmd_ch = '0;
  logic [17:0]           cmd_width = '0;
  logic [NCH-1:0]        servo_out;
  logic                  frame_start;
  logic [1:0]            active_ch;
  logic                  pulse_active;
  servo_pkg::servo_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_no = 0;
  int w_exp [NCH];

  servo_frame_scheduler #(
    .FRAME_TICKS (FT),
    .N_CH        (NCH),
    .MIN_TICKS   (MINW),
    .MAX_TICKS   (MAXW),
    .CENTER_TICKS(CENW),
    .GAP_TICKS   (GAPW),
    .SLEW_TICKS  (SLEW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ch      (cmd_ch),
    .cmd_width   (cmd_width),
    .servo_out   (servo_out),
    .frame_start (frame_start),
    .active_ch   (active_ch),
    .pulse_active(pulse_active),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_servo"}, servo_out, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_active_ch"}, active_ch, 0);
    check({tag, "_pulse_active"}, pulse_active, 0);
  endtask

  // Starts at the negedge of fcnt==0 and ends at the negedge of the next frame's fcnt==0.
  // Up to two commands are presented at the given frame offsets (-1 = none).
  task automatic check_frame(input int c0_t, input int c0_ch, input int c0_w,
                             input int c1_t, input int c1_ch, input int c1_w);
    int rise [NCH];
    int acc;
    int exp_a;
    logic [NCH-1:0] exp_s;
    frame_no++;
    acc = 0;
    for (int i = 0; i < NCH; i++) begin
      rise[i] = acc;
      acc += w_exp[i] + GAPW;
    end
    check($sformatf("f%0d_cmd_ready", frame_no), cmd_ready, 1);
    for (int t = 0; t < FT; t++) begin
      exp_s = '0;
      exp_a = 0;
      for (int i = 0; i < NCH; i++) begin
        if (t >= rise[i] && t < rise[i] + w_exp[i]) exp_s[i] = 1'b1;
        if (t >= rise[i]) exp_a = i;
      end
      check($sformatf("f%0d_servo_t%0d", frame_no, t), servo_out, exp_s);
      check($sformatf("f%0d_frame_start_t%0d", frame_no, t), frame_start, (t == 0) ? 1 : 0);
      check($sformatf("f%0d_active_ch_t%0d", frame_no, t), active_ch, exp_a);
      check($sformatf("f%0d_pulse_active_t%0d", frame_no, t), pulse_active, (exp_s != 0) ? 1 : 0);
      if (t == c0_t) begin
        cmd_valid = 1'b1;
        cmd_ch    = 2'(c0_ch);
        cmd_width = 18'(c0_w);
      end else if (t == c1_t) begin
        cmd_valid = 1'b1;
        cmd_ch    = 2'(c1_ch);
        cmd_width = 18'(c1_w);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: neutral widths; request ch1 below range and ch3 above range.
    w_exp = '{CENW, CENW, CENW, CENW};
    check_frame(10, 1, 2, 20, 3, 30);

    // Frame 2: clamped widths (slewed toward them if enabled); ch0 written in the wrap cycle.
`ifdef SERVO_SLEW_EN
    w_exp = '{15, 13, 15, 17};
`else
    w_exp = '{15, 5, 15, 25};
`endif
    check_frame(FT - 1, 0, 20, -1, 0, 0);

    // Frame 3: wrap-cycle command not yet visible.
`ifdef SERVO_SLEW_EN
    w_exp = '{15, 11, 15, 19};
`else
    w_exp = '{15, 5, 15, 25};
`endif
    check_frame(-1, 0, 0, -1, 0, 0);

    // Frame 4: ch0 update now in effect.
`ifdef SERVO_SLEW_EN
    w_exp = '{17, 9, 15, 21};
`else
    w_exp = '{20, 5, 15, 25};
`endif
    check_frame(-1, 0, 0, -1, 0, 0);

    // Frame 5: reset while channel 1 is high.
    repeat (24) @(negedge clk);
    check("mid_ch1_servo", servo_out, 4'b0010);
    check("mid_ch1_active_ch", active_ch, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    repeat (3) @(negedge clk);
    check_idle_outputs("held_rst");
    rst = 1'b0;
    @(negedge clk);

    // After release: everything back to neutral, frame starts on the first cycle.
    w_exp = '{CENW, CENW, CENW, CENW};
    check_frame(-1, 0, 0, -1, 0, 0);
    check_frame(-1, 0, 0, -1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_frame_scheduler.md
# servo_frame_scheduler

Multi-channel servo pulse scheduler for the flight stabiliser's actuator stage. It owns the 50 Hz frame timebase (20 ms = 2,000,000 cycles at 100 MHz) and accepts per-channel pulse-width commands from the attitude/angle-mapping logic. Each frame it emits one servo pulse per channel, sequenced back-to-back so that no two servos switch together. Commanded widths are clamped to the safe servo range and, optionally, slew-limited per frame.

## Interface
- FRAME_TICKS, 2000000, frame period in clk cycles (50 Hz at 100 MHz)
- N_CH, 4, number of servo channels (2..8)
- MIN_TICKS, 50000, minimum pulse width (0.5 ms, -90°)
- MAX_TICKS, 250000, maximum pulse width (2.5 ms, +90°)
- CENTER_TICKS, 150000, reset/neutral pulse width (1.5 ms, 0°)
- GAP_TICKS, 25000, low time between the falling edge of channel i and the rising edge of channel i+1
- SLEW_TICKS, 12500, maximum width change per frame per channel (only used with the slew-limit macro)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  width command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_ch  in  $clog2(N_CH)  target channel
- cmd_width  in  18  requested pulse width in cycles
- servo_out  out  N_CH  per-channel servo PWM
- frame_start  out  1  one-cycle pulse at frame start
- active_ch  out  $clog2(N_CH)  channel currently pulsing or last pulsed
- pulse_active  out  1  high while any servo_out bit is high

## Operation
- Parameter legality: N_CH*(MAX_TICKS+GAP_TICKS) <= FRAME_TICKS and MIN_TICKS <= CENTER_TICKS <= MAX_TICKS. A violation is an elaboration error.
- Registers:
  - fcnt: frame counter, 0..FRAME_TICKS-1, wraps to 0.
  - shadow[N_CH]: commanded widths.
  - width[N_CH]: widths in use for the current frame.
  - pcnt: pulse/gap counter.
- Commands: cmd_ready = 1 whenever not in reset. On an accepted command, shadow[cmd_ch] <= clamp(cmd_width, MIN_TICKS, MAX_TICKS). If cmd_ch >= N_CH, the command is accepted and discarded.
- Frame latch: on the edge where fcnt wraps from FRAME_TICKS-1 to 0, each width[i] <= next(shadow[i], width[i]).
- A command accepted in the wrap cycle updates shadow only. It is not used until the following wrap.
- FSM states: IDLE, PULSE, GAP, HOLD.
  - IDLE: entered from reset only. Moves to PULSE for channel 0 at the first wrap.
  - PULSE(ch): servo_out[ch] = 1 for exactly width[ch] cycles. Then goes to GAP, or to HOLD if ch = N_CH-1.
  - GAP: all servo_out low for exactly GAP_TICKS cycles, then PULSE(ch+1).
  - HOLD: all low until wrap, then PULSE(0).
- At every wrap the FSM forces PULSE(0), whatever its current state. Legal parameters guarantee HOLD has already been reached.
- Only one servo_out bit is high at a time.
- active_ch follows the PULSE channel and holds its value through GAP and HOLD.

## Timing
- Reset values:
  - fcnt = FRAME_TICKS-1
  - shadow and width = CENTER_TICKS
  - FSM = IDLE
  - servo_out = 0, frame_start = 0, active_ch = 0, pulse_active = 0, cmd_ready = 0
- The first edge after reset release wraps fcnt. frame_start is high in the fcnt==0 cycle.
- All outputs are registered.
- servo_out[0] is high for fcnt = 0..width[0]-1.
- Channel i rises at fcnt = sum over j<i of (width[j]+GAP_TICKS).
- Frame period is exactly FRAME_TICKS cycles, independent of widths.
- Command to output latency: at most one frame plus one cycle, i.e. the first wrap strictly after the accept cycle.
- Reset asserted mid-pulse: servo_out drops low asynchronously and all state returns to reset values. There is no partial pulse after release.

## Configuration
- SERVO_SLEW_EN defined: next(s,w) = w + clamp(s-w, -SLEW_TICKS, +SLEW_TICKS).
- SERVO_SLEW_EN undefined: next(s,w) = s. The full jump takes effect at the next frame.

## Structure
- Shared package servo_pkg holds:
  - the default tick constants (FRAME_TICKS, MIN/MAX/CENTER_TICKS, GAP_TICKS, SLEW_TICKS)
  - the width type (18-bit)
  - the FSM state enum
- One natural sub-module: servo_width_limiter (combinational clamp plus slew step), used at both command write and frame latch.

## Test plan
- Reset, then no commands: all 4 channels pulse 150000 cycles; rises at fcnt 0, 175000, 350000, 525000; frame_start every 2,000,000 cycles.
- Write ch2 = 250000 with SERVO_SLEW_EN: ch2 widths are 162500, 175000, … and reach 250000 on the 8th frame, then stay.
- Write ch1 = 10000 and ch3 = 260000: the next frames use widths clamped to 50000 and 250000.
- Write ch0 = 200000 in the fcnt == FRAME_TICKS-1 cycle, macro undefined: the next frame still uses 150000; the frame after uses 200000.
- Assert rst during the ch1 pulse: servo_out goes to 0 immediately. After release, frame_start is asserted on the first cycle and all widths are 150000.
- cmd_ch = 5 with N_CH = 4: the command is accepted and no width changes.
